// File: rtl/mem_responder.sv
// mem_responder: serves imem/dmem requests on one single-ported RAM, data first.
// Latency: request seen at edge N, RAM enables from N+1, hit the cycle after ACCESS.
// Backpressure: requests held until hit; RAM stalls via BUSY, bounded by TIMEOUT.
//
// Ports:
//   CLK, RST                          clock, synchronous active-high reset
//   imemREN/imemaddr                  instruction read request (held until ihit)
//   dmemREN/dmemWEN/dmemaddr/dmemstore data request (held until dhit)
//   ihit/imemload, dhit/dmemload      one-cycle completion pulses with load data
//   ramREN/ramWEN/ramaddr/ramstore    RAM request, driven only while accessing
//   ramload/ramstate                  RAM response (FREE/BUSY/ACCESS/ERROR)
//   err                               sticky: some access ended by ERROR or timeout
module mem_responder #(
  parameter int          DATA_W   = 32,
  parameter int          ADDR_W   = 32,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_WORD = 32'hBAD1BAD1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              imemREN,
  input  logic [ADDR_W-1:0] imemaddr,
  input  logic              dmemREN,
  input  logic              dmemWEN,
  input  logic [ADDR_W-1:0] dmemaddr,
  input  logic [DATA_W-1:0] dmemstore,
  output logic              ihit,
  output logic [DATA_W-1:0] imemload,
  output logic              dhit,
  output logic [DATA_W-1:0] dmemload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              err
);

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  // Completion fires on the TIMEOUT-th cycle spent in an access state.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [DATA_W-1:0] ERR_LOAD = DATA_W'(ERR_WORD);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DACC = 2'd1,
    IACC = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                is_data_q, is_data_d;
  logic                wen_q, wen_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   store_q, store_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   iload_q, iload_d;
  logic [DATA_W-1:0]   dload_q, dload_d;
  logic                err_q, err_d;

  logic                in_acc;
  logic                withdrawn;
  logic                fail;
  logic [DATA_W-1:0]   done_word;

  assign in_acc = (state_q == DACC) || (state_q == IACC);

  // The requester keeps its enable high until the hit; dropping it early
  // abandons the access.
  assign withdrawn = is_data_q ? !(dmemREN || dmemWEN) : !imemREN;

  assign fail      = (ramstate == RAM_ERROR) || (cnt_q == CNT_LAST);
  assign done_word = (ramstate == RAM_ACCESS) ? ramload : ERR_LOAD;

  always_comb begin
    state_d   = state_q;
    is_data_d = is_data_q;
    wen_d     = wen_q;
    addr_d    = addr_q;
    store_d   = store_q;
    cnt_d     = cnt_q;
    iload_d   = iload_q;
    dload_d   = dload_q;
    err_d     = err_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (dmemREN || dmemWEN) begin
          state_d   = DACC;
          is_data_d = 1'b1;
          wen_d     = dmemWEN;  // REN+WEN together is a write
          addr_d    = dmemaddr;
          store_d   = dmemstore;
        end else if (imemREN) begin
          state_d   = IACC;
          is_data_d = 1'b0;
          wen_d     = 1'b0;
          addr_d    = imemaddr;
          store_d   = '0;
        end
      end

      DACC, IACC: begin
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (withdrawn) begin
          state_d = IDLE;
        end else if ((ramstate == RAM_ACCESS) || fail) begin
          state_d = RESP;
          if (ramstate != RAM_ACCESS) begin
            err_d = 1'b1;
          end
          if (is_data_q) begin
            // A successful write returns zero; an errored one still flags ERR_WORD.
            dload_d = (wen_q && (ramstate == RAM_ACCESS)) ? '0 : done_word;
          end else begin
            iload_d = done_word;
          end
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      is_data_q <= 1'b0;
      wen_q     <= 1'b0;
      addr_q    <= '0;
      store_q   <= '0;
      cnt_q     <= '0;
      iload_q   <= '0;
      dload_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_data_q <= is_data_d;
      wen_q     <= wen_d;
      addr_q    <= addr_d;
      store_q   <= store_d;
      cnt_q     <= cnt_d;
      iload_q   <= iload_d;
      dload_q   <= dload_d;
      err_q     <= err_d;
    end
  end

  assign ramREN   = in_acc && !wen_q;
  assign ramWEN   = in_acc && wen_q;
  assign ramaddr  = in_acc ? addr_q : '0;
  assign ramstore = in_acc ? store_q : '0;

  assign ihit     = (state_q == RESP) && !is_data_q;
  assign dhit     = (state_q == RESP) && is_data_q;
  assign imemload = iload_q;
  assign dmemload = dload_q;
  assign err      = err_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  logic        CLK = 1'b0;
  logic        RST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        ihit;
  logic [31:0] imemload;
  logic        dhit;
  logic [31:0] dmemload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        err;

  int total = 0;
  int bad   = 0;

  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  mem_responder dut (
    .CLK(CLK), .RST(RST),
    .imemREN(imemREN), .imemaddr(imemaddr),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .ihit(ihit), .imemload(imemload), .dhit(dhit), .dmemload(dmemload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  initial begin
    int n;
    int guard;

    RST = 1'b1; imemREN = 1'b1; imemaddr = 32'h40; dmemREN = 1'b1; dmemWEN = 1'b0;
    dmemaddr = 32'h80; dmemstore = 32'h0; ramload = 32'h0; ramstate = FREE;

    // Reset held with requests high
    cyc(); cyc();
    chk("rst_ihit",     {31'd0, ihit},   32'd0);
    chk("rst_dhit",     {31'd0, dhit},   32'd0);
    chk("rst_ramREN",   {31'd0, ramREN}, 32'd0);
    chk("rst_ramWEN",   {31'd0, ramWEN}, 32'd0);
    chk("rst_err",      {31'd0, err},    32'd0);
    chk("rst_imemload", imemload,        32'd0);
    chk("rst_dmemload", dmemload,        32'd0);
    chk("rst_ramaddr",  ramaddr,         32'd0);
    imemREN = 1'b0; dmemREN = 1'b0;
    RST = 1'b0;
    cyc();

    // Single ifetch, two BUSY cycles then ACCESS
    imemREN = 1'b1; imemaddr = 32'h40; ramstate = BUSY;
    cyc();
    chk("if_ramREN",  {31'd0, ramREN}, 32'd1);
    chk("if_ramWEN",  {31'd0, ramWEN}, 32'd0);
    chk("if_ramaddr", ramaddr,         32'h40);
    cyc();
    chk("if_busy_ihit", {31'd0, ihit}, 32'd0);
    ramstate = ACCESS; ramload = 32'h8C220004;
    cyc();
    chk("if_ihit",     {31'd0, ihit},   32'd1);
    chk("if_dhit",     {31'd0, dhit},   32'd0);
    chk("if_imemload", imemload,        32'h8C220004);
    chk("if_ren_drop", {31'd0, ramREN}, 32'd0);
    imemREN = 1'b0; ramstate = FREE;
    cyc();
    chk("if_ihit_once", {31'd0, ihit}, 32'd0);

    // Simultaneous imem read and dmem write: write goes first
    imemREN = 1'b1; imemaddr = 32'h40;
    dmemWEN = 1'b1; dmemaddr = 32'h100; dmemstore = 32'hDEADBEEF;
    ramstate = ACCESS; ramload = 32'h55555555;
    cyc();
    chk("wr_ramWEN",   {31'd0, ramWEN}, 32'd1);
    chk("wr_ramREN",   {31'd0, ramREN}, 32'd0);
    chk("wr_ramaddr",  ramaddr,         32'h100);
    chk("wr_ramstore", ramstore,        32'hDEADBEEF);
    cyc();
    chk("wr_dhit",     {31'd0, dhit},   32'd1);
    chk("wr_ihit",     {31'd0, ihit},   32'd0);
    chk("wr_dmemload", dmemload,        32'd0);
    chk("wr_wen_drop", {31'd0, ramWEN}, 32'd0);
    dmemWEN = 1'b0;
    cyc();
    chk("wr_idle_ren", {31'd0, ramREN}, 32'd0);
    chk("wr_idle_hit", {31'd0, ihit | dhit}, 32'd0);
    ramload = 32'h11112222;
    cyc();
    chk("rd2_ramREN",  {31'd0, ramREN}, 32'd1);
    chk("rd2_ramaddr", ramaddr,         32'h40);
    cyc();
    chk("rd2_ihit",     {31'd0, ihit}, 32'd1);
    chk("rd2_imemload", imemload,      32'h11112222);
    imemREN = 1'b0; ramstate = FREE;
    cyc();

    // RAM ERROR on a data read
    dmemREN = 1'b1; dmemaddr = 32'h200; ramstate = ERROR;
    cyc();
    chk("er_ramREN", {31'd0, ramREN}, 32'd1);
    chk("er_err_pre", {31'd0, err},   32'd0);
    cyc();
    chk("er_dhit",     {31'd0, dhit}, 32'd1);
    chk("er_dmemload", dmemload,      32'hBAD1BAD1);
    chk("er_err",      {31'd0, err},  32'd1);
    dmemREN = 1'b0; ramstate = FREE;
    cyc();
    chk("er_err_sticky", {31'd0, err}, 32'd1);
    chk("er_dhit_once",  {31'd0, dhit}, 32'd0);

    // RAM stuck BUSY: forced completion after TIMEOUT access cycles
    dmemREN = 1'b1; dmemaddr = 32'h300; ramstate = BUSY;
    cyc();
    n = 0; guard = 0;
    while (!dhit && guard < 400) begin
      if (ramREN) n++;
      guard++;
      cyc();
    end
    chk("to_dhit",     {31'd0, dhit}, 32'd1);
    chk("to_cycles",   n,             32'd255);
    chk("to_dmemload", dmemload,      32'hBAD1BAD1);
    chk("to_err",      {31'd0, err},  32'd1);
    dmemREN = 1'b0; ramstate = FREE;
    cyc();

    // Requester withdraws while waiting
    dmemREN = 1'b1; dmemaddr = 32'h400; ramstate = BUSY;
    cyc();
    chk("wd_ramREN", {31'd0, ramREN}, 32'd1);
    dmemREN = 1'b0;
    cyc();
    chk("wd_ren_drop", {31'd0, ramREN}, 32'd0);
    chk("wd_no_dhit",  {31'd0, dhit},   32'd0);
    cyc();
    chk("wd_no_dhit2", {31'd0, dhit},   32'd0);

    // Reset in the middle of an access: no hit, err cleared
    dmemREN = 1'b1; dmemaddr = 32'h500;
    cyc();
    RST = 1'b1; ramstate = ACCESS; dmemREN = 1'b0;
    cyc();
    chk("mr_dhit",   {31'd0, dhit},   32'd0);
    chk("mr_ramREN", {31'd0, ramREN}, 32'd0);
    chk("mr_err",    {31'd0, err},    32'd0);
    RST = 1'b0; ramstate = FREE;
    cyc();
    chk("mr_dhit_after", {31'd0, dhit}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
